// File: rtl/bnn_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : bnn_exec_unit
// Description : Multi-cycle binary-neural-network execute unit. Computes the
//               XNOR-popcount of two operands over POP_PER_CYCLE-bit slices,
//               maintains a saturating signed accumulator, and stalls the
//               pipeline through BusyE while counting.
//               Optional feature macro: BNN_THRESHOLD_EN (THRESH compare).
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_exec_unit #(
    parameter int XLEN          = 32,
    parameter int POP_PER_CYCLE = 8,
    parameter int ACC_W         = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic [1:0]      FuncE,
    input  logic [XLEN-1:0] OpA_E,
    input  logic [XLEN-1:0] OpB_E,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] BNNResult
);

    localparam int N  = XLEN / POP_PER_CYCLE;
    localparam int PW = $clog2(XLEN + 1);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    // Sum width: room for the sign-extended accumulator plus the +/-XLEN term
    localparam int SW = ((ACC_W > PW + 1) ? ACC_W : PW + 1) + 2;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_COUNT = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;

    localparam logic [1:0] c_F_XNORPOP = 2'b00;
    localparam logic [1:0] c_F_XNORACC = 2'b01;
    localparam logic [1:0] c_F_ACCCLR  = 2'b10;

    localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [SW-1:0]    c_SAT_MAX = SW'(c_ACC_MAX);
    localparam logic [SW-1:0]    c_SAT_MIN = SW'($signed(c_ACC_MIN));
    localparam logic [SW-1:0]    c_XLEN_S  = SW'(XLEN);

    // Reject illegal parameter combinations at elaboration
    generate
        if ((XLEN % POP_PER_CYCLE) != 0) begin : g_bad_slice
            $error("XLEN must be a multiple of POP_PER_CYCLE");
        end
        if (ACC_W > XLEN) begin : g_bad_accw
            $error("ACC_W must not exceed XLEN");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       r_func;
    logic [XLEN-1:0]  r_xnor;     // consumed from the LSB end, one slice per cycle
    logic [KW-1:0]    r_k;
    logic [PW-1:0]    r_pop;
    logic [ACC_W-1:0] r_acc;
    logic [XLEN-1:0]  r_result;

    logic [PW-1:0]    w_slice_pop;
    logic [PW-1:0]    w_pop_final;
    logic [SW-1:0]    w_sum;
    logic [ACC_W-1:0] w_acc_new;
    logic [XLEN-1:0]  w_thr_result;
    logic             w_accept;
    logic             w_last;

    assign w_accept    = (r_state != c_S_COUNT) && StartE && !FlushE;
    assign w_last      = (r_k == KW'(N - 1));
    assign w_pop_final = r_pop + w_slice_pop;

    assign BusyE     = (r_state == c_S_COUNT) || (w_accept && !FuncE[1]);
    assign DoneE     = (r_state == c_S_DONE);
    assign BNNResult = r_result;

    // Popcount of the current slice (low POP_PER_CYCLE bits of the shifter)
    always_comb begin
        w_slice_pop = '0;
        for (int i = 0; i < POP_PER_CYCLE; i++) begin
            w_slice_pop = w_slice_pop + PW'(r_xnor[i]);
        end
    end

    // acc + (2*pop - XLEN), clamped to the signed ACC_W range
    always_comb begin
        w_sum = SW'($signed(r_acc)) + SW'({w_pop_final, 1'b0}) - c_XLEN_S;
        if ($signed(w_sum) > $signed(c_SAT_MAX)) begin
            w_acc_new = c_ACC_MAX;
        end else if ($signed(w_sum) < $signed(c_SAT_MIN)) begin
            w_acc_new = c_ACC_MIN;
        end else begin
            w_acc_new = w_sum[ACC_W-1:0];
        end
    end

`ifdef BNN_THRESHOLD_EN
    // Threshold compare uses the live operand since THRESH commits at accept
    assign w_thr_result = XLEN'($signed(r_acc) >= $signed(OpA_E[ACC_W-1:0]));
`else
    assign w_thr_result = '0;
`endif

    // Control FSM, slice counter, accumulator and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_func   <= '0;
            r_xnor   <= '0;
            r_k      <= '0;
            r_pop    <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (r_state == c_S_COUNT) begin
            if (FlushE) begin
                r_state <= c_S_IDLE;
            end else begin
                r_pop  <= w_pop_final;
                r_xnor <= r_xnor >> POP_PER_CYCLE;
                r_k    <= r_k + KW'(1);
                if (w_last) begin
                    r_state <= c_S_DONE;
                    if (r_func == c_F_XNORACC) begin
                        r_acc    <= w_acc_new;
                        r_result <= XLEN'($signed(w_acc_new));
                    end else begin
                        r_result <= XLEN'(w_pop_final);
                    end
                end
            end
        end else if (w_accept) begin
            r_func <= FuncE;
            if (FuncE == c_F_XNORPOP || FuncE == c_F_XNORACC) begin
                r_state <= c_S_COUNT;
                r_xnor  <= ~(OpA_E ^ OpB_E);
                r_k     <= '0;
                r_pop   <= '0;
            end else if (FuncE == c_F_ACCCLR) begin
                r_state  <= c_S_DONE;
                r_acc    <= '0;
                r_result <= '0;
            end else begin
                r_state  <= c_S_DONE;
                r_result <= w_thr_result;
            end
        end else begin
            r_state <= c_S_IDLE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_exec_unit
// Description : Directed self-checking bench for bnn_exec_unit (ACC_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_exec_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            StartE;
    logic [1:0]      FuncE;
    logic [XLEN-1:0] OpA_E;
    logic [XLEN-1:0] OpB_E;
    logic            FlushE;
    logic            BusyE;
    logic            DoneE;
    logic [XLEN-1:0] BNNResult;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;
    int bsy;

    bnn_exec_unit #(.XLEN(32), .POP_PER_CYCLE(8), .ACC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .StartE    (StartE),
        .FuncE     (FuncE),
        .OpA_E     (OpA_E),
        .OpB_E     (OpB_E),
        .FlushE    (FlushE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .BNNResult (BNNResult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op now; returns at the DONE cycle (sampled 3 units later)
    // with latency in cycles and the number of cycles BusyE was high.
    task automatic do_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int latency, output int busy_cnt);
        StartE = 1'b1; FuncE = f; OpA_E = a; OpB_E = b;
        busy_cnt = 0;
        #3;
        if (BusyE) busy_cnt++;
        for (latency = 1; latency <= 20; latency++) begin
            tick();
            StartE = 1'b0;
            #3;
            if (DoneE) break;
            if (BusyE) busy_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; StartE = 1'b0; FuncE = 2'b00; OpA_E = '0; OpB_E = '0; FlushE = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #3;
        chk("reset_result", BNNResult, 32'd0);
        chk("reset_done", {31'd0, DoneE}, 32'd0);
        chk("reset_busy", {31'd0, BusyE}, 32'd0);
        tick();

        // XNORPOP, all bits agree
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bsy);
        chk("pop_ones_res", BNNResult, 32'd32);
        chk("pop_ones_lat", lat, 32'd5);
        chk("pop_ones_busy", bsy, 32'd5);
        chk("pop_ones_done", {31'd0, DoneE}, 32'd1);

        // Back-to-back start in the DONE cycle: all bits disagree
        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0000, lat, bsy);
        chk("pop_zero_res", BNNResult, 32'd0);
        chk("b2b_lat", lat, 32'd5);

        // xor = 0x0A0A0A0A (8 ones) -> 24 matching bits
        do_op(2'b00, 32'hAAAA_AAAA, 32'hA0A0_A0A0, lat, bsy);
        chk("pop_mix_res", BNNResult, 32'd24);
        tick();

        // Accumulator: clear, then +32 per matching op, saturate at 127
        do_op(2'b10, 32'h0, 32'h0, lat, bsy);
        chk("clr_res", BNNResult, 32'd0);
        chk("clr_lat", lat, 32'd1);
        chk("clr_busy", bsy, 32'd0);
        do_op(2'b01, 32'h1234_5678, 32'h1234_5678, lat, bsy);
        chk("acc_32", BNNResult, 32'd32);
        do_op(2'b01, 32'h1234_5678, 32'h1234_5678, lat, bsy);
        chk("acc_64", BNNResult, 32'd64);

        // THRESH at acc=64
        do_op(2'b11, 32'd64, 32'd0, lat, bsy);
`ifdef BNN_THRESHOLD_EN
        chk("thr_64", BNNResult, 32'd1);
`else
        chk("thr_64", BNNResult, 32'd0);
`endif
        chk("thr_lat", lat, 32'd1);
        chk("thr_busy", bsy, 32'd0);
        do_op(2'b11, 32'd65, 32'd0, lat, bsy);
        chk("thr_65", BNNResult, 32'd0);

        do_op(2'b01, 32'h0, 32'h0, lat, bsy);
        chk("acc_96", BNNResult, 32'd96);
        do_op(2'b01, 32'h0, 32'h0, lat, bsy);
        chk("acc_sat_hi", BNNResult, 32'd127);
        do_op(2'b01, 32'h0, 32'h0, lat, bsy);
        chk("acc_sat_hi2", BNNResult, 32'd127);

        // Negative direction: -32 per op from a cleared acc
        do_op(2'b10, 32'h0, 32'h0, lat, bsy);
        for (int i = 1; i <= 5; i++) begin
            do_op(2'b01, 32'h5555_5555, 32'hAAAA_AAAA, lat, bsy);
        end
        chk("acc_sat_lo", BNNResult, 32'hFFFF_FF80);

        // Flush in COUNT cycle 2: no commit
        do_op(2'b10, 32'h0, 32'h0, lat, bsy);
        do_op(2'b01, 32'h0, 32'h0, lat, bsy);
        chk("flush_pre", BNNResult, 32'd32);
        tick();
        StartE = 1'b1; FuncE = 2'b01; OpA_E = 32'h0; OpB_E = 32'h0;
        tick(); StartE = 1'b0;                     // cycle 1
        tick(); FlushE = 1'b1;                     // cycle 2
        tick(); FlushE = 1'b0; #3;                 // cycle 3
        chk("flush2_done", {31'd0, DoneE}, 32'd0);
        chk("flush2_busy", {31'd0, BusyE}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); #3;
            chk("flush2_nodone", {31'd0, DoneE}, 32'd0);
        end
        chk("flush2_res", BNNResult, 32'd32);

        // Flush on the final COUNT cycle (cycle 4)
        tick();
        StartE = 1'b1; FuncE = 2'b01;
        tick(); StartE = 1'b0;
        tick(); tick(); tick(); FlushE = 1'b1;      // cycle 4
        tick(); FlushE = 1'b0; #3;                  // cycle 5
        chk("flush4_done", {31'd0, DoneE}, 32'd0);
        chk("flush4_res", BNNResult, 32'd32);
        tick();
        do_op(2'b01, 32'h0, 32'h0, lat, bsy);
        chk("flush_acc_kept", BNNResult, 32'd64);
        tick();

        // Reset during COUNT
        StartE = 1'b1; FuncE = 2'b01; OpA_E = 32'h0; OpB_E = 32'h0;
        tick(); StartE = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; #3;
        chk("rst_mid_done", {31'd0, DoneE}, 32'd0);
        chk("rst_mid_busy", {31'd0, BusyE}, 32'd0);
        chk("rst_mid_res", BNNResult, 32'd0);
        tick();
        do_op(2'b01, 32'hAAAA_AAAA, 32'hA0A0_A0A0, lat, bsy);
        chk("rst_acc_mix", BNNResult, 32'd16);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
